// File: rtl/gf_syndrome_bank.sv
// Parallel Reed-Solomon syndrome bank: NUM_SYN GF(2^SYM_W) Horner accumulators over one block.
// Optional registered all-zero flag output syn_zero when RSDEC_SYN_ZERO_FLAG_EN is defined.
module gf_syndrome_bank #(
    parameter int               SYM_W     = 5,
    parameter int               NUM_SYN   = 4,
    parameter int               BLK_LEN   = 31,
    parameter logic [SYM_W-1:0] PRIM_POLY = 5'b00101,
    parameter int               FCR       = 1
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       start,
    input  logic [SYM_W-1:0]           datain,
    input  logic                       din_valid,
    input  logic                       hold,
    output logic                       busy,
    output logic                       done,
    output logic [NUM_SYN*SYM_W-1:0]   syndromes
`ifdef RSDEC_SYN_ZERO_FLAG_EN
    ,
    output logic                       syn_zero
`endif
);

    localparam int CNT_W = $clog2(BLK_LEN + 1);
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] ACC  = 1'b1;

    // Multiply by x, reduced modulo the primitive polynomial.
    function automatic logic [SYM_W-1:0] xtime(input logic [SYM_W-1:0] a);
        return {a[SYM_W-2:0], 1'b0} ^ (a[SYM_W-1] ? PRIM_POLY : '0);
    endfunction

    function automatic logic [SYM_W-1:0] gf_mul(input logic [SYM_W-1:0] a,
                                                input logic [SYM_W-1:0] b);
        logic [SYM_W-1:0] p;
        logic [SYM_W-1:0] x;
        p = '0;
        x = a;
        for (int k = 0; k < SYM_W; k++) begin
            if (b[k]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    function automatic logic [SYM_W-1:0] gf_pow_alpha(input int e);
        logic [SYM_W-1:0] r;
        r    = '0;
        r[0] = 1'b1;
        for (int k = 0; k < e; k++) r = xtime(r);
        return r;
    endfunction

    logic [0:0]               state_reg;
    logic [CNT_W-1:0]         count_reg;
    logic                     done_reg;
    logic [NUM_SYN*SYM_W-1:0] syn_reg;
    logic [NUM_SYN*SYM_W-1:0] acc_next;
    logic                     accept;
    logic                     step;
    logic                     last;

    // hold outranks din_valid; start outranks a normal accumulate step.
    assign accept = din_valid && !hold;
    assign step   = (state_reg == ACC) && accept && !start;
    assign last   = step && (count_reg == CNT_W'(BLK_LEN - 1));

    for (genvar gi = 0; gi < NUM_SYN; gi++) begin : g_ch
        localparam logic [SYM_W-1:0] ROOT = gf_pow_alpha(FCR + gi);
        logic [SYM_W-1:0] acc_reg;

        assign acc_next[gi*SYM_W +: SYM_W] = gf_mul(acc_reg, ROOT) ^ datain;

        always_ff @(posedge clock) begin
            if (reset) begin
                acc_reg <= '0;
            end else if (start) begin
                acc_reg <= accept ? datain : '0;
            end else if (step) begin
                acc_reg <= acc_next[gi*SYM_W +: SYM_W];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg <= IDLE;
            count_reg <= '0;
            done_reg  <= 1'b0;
            syn_reg   <= '0;
        end else begin
            done_reg <= last;
            if (start) begin
                state_reg <= ACC;
                count_reg <= accept ? CNT_W'(1) : '0;
            end else if (last) begin
                state_reg <= IDLE;
                count_reg <= '0;
                syn_reg   <= acc_next;
            end else if (step) begin
                count_reg <= count_reg + CNT_W'(1);
            end
        end
    end

`ifdef RSDEC_SYN_ZERO_FLAG_EN
    logic syn_zero_reg;

    always_ff @(posedge clock) begin
        if (reset) begin
            syn_zero_reg <= 1'b1;
        end else if (last && !start) begin
            syn_zero_reg <= (acc_next == '0);
        end
    end

    assign syn_zero = syn_zero_reg;
`endif

    assign busy      = (state_reg == ACC);
    assign done      = done_reg;
    assign syndromes = syn_reg;

endmodule

// File: tb/tb_gf_syndrome_bank.sv
// Self-checking bench for gf_syndrome_bank (default parameters, GF(32), 4 syndromes).
module tb_gf_syndrome_bank;

    localparam int N = 31;

    logic        clk = 1'b0;
    logic        reset, start, din_valid, hold;
    logic [4:0]  datain;
    logic        busy, done;
    logic [19:0] syndromes;
`ifdef RSDEC_SYN_ZERO_FLAG_EN
    logic        syn_zero;
`endif

    gf_syndrome_bank dut (
        .clock     (clk),
        .reset     (reset),
        .start     (start),
        .datain    (datain),
        .din_valid (din_valid),
        .hold      (hold),
        .busy      (busy),
        .done      (done),
        .syndromes (syndromes)
`ifdef RSDEC_SYN_ZERO_FLAG_EN
        ,
        .syn_zero  (syn_zero)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int done_count = 0;

    always @(negedge clk) if (done) done_count++;

    // Antilog / log tables of alpha in GF(32), x^5+x^2+1.
    logic [4:0] exp_t [31];
    int         log_t [32];

    typedef struct {
        int          pos;
        logic [4:0]  val;
        logic [19:0] exp_syn;
        bit          exp_zero;
    } vec_t;

    vec_t vecs [4];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %h want %h", name, got, want);
        end
    endtask

    // Direct polynomial evaluation: S_i = sum_j r_j * alpha^((1+i)*(n-1-j)).
    function automatic logic [19:0] ref_syn(input logic [4:0] blk [31]);
        logic [19:0] r;
        logic [4:0]  s;
        r = '0;
        for (int i = 0; i < 4; i++) begin
            s = '0;
            for (int j = 0; j < N; j++)
                if (blk[j] != 5'd0)
                    s = s ^ exp_t[(log_t[blk[j]] + (1 + i) * (N - 1 - j)) % 31];
            r[i*5 +: 5] = s;
        end
        return r;
    endfunction

    task automatic feed_block(input logic [4:0] blk [31], input int stall_at, input int stall_len,
                              input int gap_at, input int gap_len);
        bit early;
        early     = 1'b0;
        start     = 1'b1;
        hold      = 1'b0;
        din_valid = 1'b1;
        datain    = blk[0];
        tick();
        start = 1'b0;
        if (done) early = 1'b1;
        for (int j = 1; j < N; j++) begin
            if (j == stall_at) begin
                repeat (stall_len) begin
                    hold = 1'b1; din_valid = 1'b1; datain = 5'($urandom);
                    tick();
                    if (done) early = 1'b1;
                end
                hold = 1'b0;
            end
            if (j == gap_at) begin
                repeat (gap_len) begin
                    din_valid = 1'b0; datain = 5'($urandom);
                    tick();
                    if (done) early = 1'b1;
                end
            end
            din_valid = 1'b1;
            datain    = blk[j];
            tick();
            if (j < N - 1 && done) early = 1'b1;
        end
        din_valid = 1'b0;
        check("early_done", 32'(early), 32'd0);
        check("done_pulse", 32'(done), 32'd1);
        check("busy_after", 32'(busy), 32'd0);
    endtask

    logic [4:0]  blk [31];
    logic [19:0] want;
    int          dc0;

    initial begin
        exp_t[0] = 5'd1;
        log_t[1] = 0;
        for (int k = 1; k < 31; k++) begin
            exp_t[k] = {exp_t[k-1][3:0], 1'b0} ^ (exp_t[k-1][4] ? 5'b00101 : 5'b00000);
            log_t[exp_t[k]] = k;
        end

        vecs[0] = '{30, 5'h00, 20'h0, 1'b1};
        vecs[1] = '{30, 5'h07, {5'h07, 5'h07, 5'h07, 5'h07}, 1'b0};
        vecs[2] = '{29, 5'h01, {5'h10, 5'h08, 5'h04, 5'h02}, 1'b0};
        vecs[3] = '{28, 5'h01, {5'h0D, 5'h0A, 5'h10, 5'h04}, 1'b0};

        reset = 1'b1; start = 1'b0; din_valid = 1'b0; hold = 1'b0; datain = '0;
        tick(); tick();
        reset = 1'b0;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_syn", 32'(syndromes), 32'd0);
`ifdef RSDEC_SYN_ZERO_FLAG_EN
        check("rst_syn_zero", 32'(syn_zero), 32'd1);
`endif

        // din_valid without start in IDLE must be ignored.
        din_valid = 1'b1; datain = 5'h1F;
        repeat (3) tick();
        din_valid = 1'b0;
        check("idle_busy", 32'(busy), 32'd0);
        check("idle_done_count", 32'(done_count), 32'd0);

        for (int v = 0; v < 4; v++) begin
            foreach (blk[j]) blk[j] = 5'h00;
            blk[vecs[v].pos] = vecs[v].val;
            feed_block(blk, -1, 0, -1, 0);
            check("vec_syn", 32'(syndromes), 32'(vecs[v].exp_syn));
`ifdef RSDEC_SYN_ZERO_FLAG_EN
            check("vec_syn_zero", 32'(syn_zero), 32'(vecs[v].exp_zero));
`endif
            $display("vec %0d syn=%h", v, syndromes);
            tick();
            check("done_width", 32'(done), 32'd0);
        end

        // Stalls and gaps mid-block must not change the result.
        foreach (blk[j]) blk[j] = 5'h00;
        blk[29] = 5'h01;
        feed_block(blk, 12, 3, 20, 2);
        check("stall_syn", 32'(syndromes), 32'({5'h10, 5'h08, 5'h04, 5'h02}));
        $display("stall block syn=%h", syndromes);
        tick();

        // Abort after 10 symbols, restart with a full block.
        dc0 = done_count;
        start = 1'b1;
        for (int j = 0; j < 10; j++) begin
            din_valid = 1'b1; datain = 5'($urandom_range(1, 31));
            tick();
            start = 1'b0;
        end
        foreach (blk[j]) blk[j] = 5'h00;
        blk[30] = 5'h07;
        feed_block(blk, -1, 0, -1, 0);
        tick();
        check("abort_done_count", 32'(done_count - dc0), 32'd1);
        check("abort_syn", 32'(syndromes), 32'({5'h07, 5'h07, 5'h07, 5'h07}));
        $display("abort block syn=%h", syndromes);

        // Reset mid-block at symbol 15.
        dc0 = done_count;
        start = 1'b1;
        for (int j = 0; j < 15; j++) begin
            din_valid = 1'b1; datain = 5'($urandom_range(1, 31));
            tick();
            start = 1'b0;
        end
        reset = 1'b1; din_valid = 1'b0;
        tick();
        reset = 1'b0;
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_syn", 32'(syndromes), 32'd0);
        repeat (3) tick();
        check("midrst_no_done", 32'(done_count - dc0), 32'd0);
        foreach (blk[j]) blk[j] = 5'($urandom);
        feed_block(blk, -1, 0, -1, 0);
        check("post_rst_syn", 32'(syndromes), 32'(ref_syn(blk)));
        $display("post-reset block syn=%h", syndromes);

        // Random back-to-back blocks (start in the done cycle) with random stalls and gaps.
        for (int b = 0; b < 20; b++) begin
            foreach (blk[j]) blk[j] = 5'($urandom);
            if (b % 5 == 0) foreach (blk[j]) blk[j] = 5'h00;
            want = ref_syn(blk);
            feed_block(blk, $urandom_range(1, 30), $urandom_range(0, 3),
                       $urandom_range(1, 30), $urandom_range(0, 3));
            check("rand_syn", 32'(syndromes), 32'(want));
`ifdef RSDEC_SYN_ZERO_FLAG_EN
            check("rand_syn_zero", 32'(syn_zero), 32'(want == 20'd0));
`endif
            $display("rand block %0d syn=%h want=%h", b, syndromes, want);
        end
        tick();
        check("final_done_low", 32'(done), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
